// File: rtl/secuenciador_contador.sv
// Sequencing controller for a counter that walks a programmable value table.
// A forced load triggers a linear search of the table. The search either
// resynchronises the index or parks in LOST. From LOST, the next step
// restarts the sequence at entry 0.
module secuenciador_contador #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             force_we,
    input  logic [WIDTH-1:0] force_val,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_len_we,
    input  logic [4:0]       cfg_len,
    output logic             cfg_ready,
    output logic [WIDTH-1:0] q,
    output logic [3:0]       idx,
    output logic             valid,
    output logic             busy,
    output logic             wrap,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SEARCH = 2'd1,
        LOST   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [4:0]       len_q, len_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] tab_q [DEPTH];

    // Config is only accepted while the search is not reading the table.
    logic cfg_ok;
    assign cfg_ok = (state_q != SEARCH);

    // Table storage: resets to the identity sequence. A write lands on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= WIDTH'(i);
            end
        end else if (cfg_we && cfg_ok) begin
            tab_q[cfg_addr] <= cfg_data;
        end
    end

    // Next-state logic. A force overrides a step, and config writes are decoded independently.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        wrap_d  = 1'b0;

        // Clamp the requested length into 1..16.
        if (cfg_len_we && cfg_ok) begin
            if (cfg_len == 5'd0) begin
                len_d = 5'd1;
            end else if (cfg_len > 5'd16) begin
                len_d = 5'd16;
            end else begin
                len_d = cfg_len;
            end
        end

        if (force_we) begin
            q_d     = force_val;
            ptr_d   = 4'd0;
            state_d = SEARCH;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        // ">=" rather than "==" so a shrunken length still wraps.
                        if ({1'b0, idx_q} >= (len_q - 5'd1)) begin
                            idx_d  = 4'd0;
                            q_d    = tab_q[0];
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                            q_d   = tab_q[idx_q + 4'd1];
                        end
                    end
                end
                SEARCH: begin
                    // One entry per cycle, lowest index first, so duplicates resolve low.
                    if (tab_q[ptr_q] == q_q) begin
                        idx_d   = ptr_q;
                        state_d = RUN;
                    end else if ({1'b0, ptr_q} == (len_q - 5'd1)) begin
                        state_d = LOST;
                    end else begin
                        ptr_d = ptr_q + 4'd1;
                    end
                end
                LOST: begin
                    // Recovery step: rejoin the sequence at its start without flagging a wrap.
                    if (en) begin
                        q_d     = tab_q[0];
                        idx_d   = 4'd0;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State and datapath registers. Reset drops everything back to a synchronised zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            q_q     <= '0;
            idx_q   <= 4'd0;
            ptr_q   <= 4'd0;
            len_q   <= 5'd16;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q         = q_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;
    assign valid     = (state_q == RUN);
    assign busy      = (state_q == SEARCH);
    assign cfg_ready = cfg_ok;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_secuenciador_contador.sv
// Bench for secuenciador_contador.
// Each driven cycle pushes the expected observation
// {busy, valid, wrap, cfg_ready, idx, q} into exp_q. The entry is popped and
// compared just after the next rising edge. idx is ignored while valid is low.
module tb_secuenciador_contador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       force_we = 1'b0;
    logic [3:0] force_val = 4'd0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = 4'd0;
    logic [3:0] cfg_data = 4'd0;
    logic       cfg_len_we = 1'b0;
    logic [4:0] cfg_len = 5'd0;
    logic       cfg_ready;
    logic [3:0] q;
    logic [3:0] idx;
    logic       valid;
    logic       busy;
    logic       wrap;
    logic [1:0] dbg_state;

    int total = 0;
    int bad = 0;
    logic [11:0] exp_q[$];

    secuenciador_contador #(.WIDTH(4), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .force_we(force_we), .force_val(force_val),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_ready(cfg_ready),
        .q(q), .idx(idx), .valid(valid), .busy(busy), .wrap(wrap), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] pk(input logic b, input logic v, input logic w,
                                       input logic r, input logic [3:0] i, input logic [3:0] qv);
        return {b, v, w, r, i, qv};
    endfunction

    function automatic logic [11:0] exp_run(input logic [3:0] i, input logic [3:0] qv, input logic w);
        return pk(1'b0, 1'b1, w, 1'b1, i, qv);
    endfunction

    function automatic logic [11:0] exp_srch(input logic [3:0] qv);
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, qv);
    endfunction

    function automatic logic [11:0] exp_lost(input logic [3:0] qv);
        return pk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, qv);
    endfunction

    function automatic logic [11:0] observe();
        return {busy, valid, wrap, cfg_ready, idx, q};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Drives one cycle with the currently set inputs, then scores the result.
    task automatic tick(input string tag, input logic [11:0] want);
        logic [11:0] got;
        logic [11:0] e;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        got = observe();
        e = exp_q.pop_front();
        if (!e[10]) begin
            got[7:4] = 4'd0;
            e[7:4] = 4'd0;
        end
        check_val(tag, {20'd0, got}, {20'd0, e});
        en = 1'b0;
        force_we = 1'b0;
        cfg_we = 1'b0;
        cfg_len_we = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check_val(tag, {20'd0, observe()}, {20'd0, exp_run(4'd0, 4'd0, 1'b0)});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [3:0] tab5 [5];
    logic [3:0] s2_q [6];
    logic [3:0] s2_i [6];

    initial begin
        tab5 = '{4'd3, 4'd7, 4'd1, 4'd12, 4'd5};
        s2_q = '{4'd7, 4'd1, 4'd12, 4'd5, 4'd3, 4'd7};
        s2_i = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

        #1;
        do_reset("reset_state");

        // 1: identity sequence with a wrap at step 16
        for (int i = 1; i <= 17; i++) begin
            en = 1'b1;
            tick("s1_step", exp_run(4'(i % 16), 4'(i % 16), (i == 16)));
        end

        // 2: programmed sequence of length 5
        do_reset("reset_s2");
        for (int k = 0; k < 5; k++) begin
            cfg_we = 1'b1;
            cfg_addr = 4'(k);
            cfg_data = tab5[k];
            tick("s2_cfg", exp_run(4'd0, 4'd0, 1'b0));
        end
        cfg_len_we = 1'b1;
        cfg_len = 5'd5;
        tick("s2_len", exp_run(4'd0, 4'd0, 1'b0));
        for (int j = 0; j < 6; j++) begin
            en = 1'b1;
            tick("s2_step", exp_run(s2_i[j], s2_q[j], (j == 4)));
        end

        // 3: forced value found at index 3; en is ignored while searching
        force_we = 1'b1;
        force_val = 4'd12;
        tick("s3_force", exp_srch(4'd12));
        en = 1'b1;
        tick("s3_busy_en", exp_srch(4'd12));
        tick("s3_busy", exp_srch(4'd12));
        tick("s3_busy", exp_srch(4'd12));
        tick("s3_found", exp_run(4'd3, 4'd12, 1'b0));
        en = 1'b1;
        tick("s3_next", exp_run(4'd4, 4'd5, 1'b0));

        // 4: forced value absent, so the controller goes LOST and then recovers
        force_we = 1'b1;
        force_val = 4'd9;
        tick("s4_force", exp_srch(4'd9));
        for (int j = 0; j < 4; j++) begin
            tick("s4_busy", exp_srch(4'd9));
        end
        tick("s4_lost", exp_lost(4'd9));
        tick("s4_lost_hold", exp_lost(4'd9));
        en = 1'b1;
        tick("s4_recover", exp_run(4'd0, 4'd3, 1'b0));

        // 5: length clamps, config blocked in SEARCH, shrink wrap, write/step overlap
        cfg_len_we = 1'b1;
        cfg_len = 5'd0;
        tick("s5_len0", exp_run(4'd0, 4'd3, 1'b0));
        for (int j = 0; j < 3; j++) begin
            en = 1'b1;
            tick("s5_len1_step", exp_run(4'd0, 4'd3, 1'b1));
        end
        cfg_len_we = 1'b1;
        cfg_len = 5'd31;
        tick("s5_len31", exp_run(4'd0, 4'd3, 1'b0));
        en = 1'b1;
        tick("s5_len16_step", exp_run(4'd1, 4'd7, 1'b0));
        force_we = 1'b1;
        force_val = 4'd7;
        tick("s5_force", exp_srch(4'd7));
        cfg_we = 1'b1;
        cfg_addr = 4'd1;
        cfg_data = 4'd9;
        tick("s5_cfg_blocked", exp_srch(4'd7));
        tick("s5_found", exp_run(4'd1, 4'd7, 1'b0));
        en = 1'b1;
        tick("s5_step", exp_run(4'd2, 4'd1, 1'b0));
        cfg_len_we = 1'b1;
        cfg_len = 5'd2;
        tick("s5_shrink", exp_run(4'd2, 4'd1, 1'b0));
        en = 1'b1;
        tick("s5_shrink_wrap", exp_run(4'd0, 4'd3, 1'b1));
        cfg_we = 1'b1;
        cfg_addr = 4'd1;
        cfg_data = 4'd10;
        en = 1'b1;
        tick("s5_wr_step_old", exp_run(4'd1, 4'd7, 1'b0));
        en = 1'b1;
        tick("s5_wrap_len2", exp_run(4'd0, 4'd3, 1'b1));
        en = 1'b1;
        tick("s5_wr_new", exp_run(4'd1, 4'd10, 1'b0));

        // 6: force beats en; reset aborts a search without a clock edge
        force_we = 1'b1;
        force_val = 4'd5;
        en = 1'b1;
        tick("s6_force_en", exp_srch(4'd5));
        tick("s6_busy", exp_srch(4'd5));
        tick("s6_lost", exp_lost(4'd5));
        force_we = 1'b1;
        force_val = 4'd4;
        tick("s6_force2", exp_srch(4'd4));
        tick("s6_busy2", exp_srch(4'd4));
        reset = 1'b1;
        #2;
        check_val("s6_async_rst", {20'd0, observe()}, {20'd0, exp_run(4'd0, 4'd0, 1'b0)});
        @(posedge clk);
        #1;
        reset = 1'b0;
        en = 1'b1;
        tick("s6_post_rst", exp_run(4'd1, 4'd1, 1'b0));

        check_val("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
